// File: rtl/opb_register_simulink2ppc_latch.sv
`default_nettype none
// ============================================================================
//  Module   : opb_register_simulink2ppc_latch
//  Purpose  : OPB slave carrying one 32-bit word from fabric to the PowerPC.
//             A valid strobe from fabric latches the word and sets a sticky
//             fresh flag. Words arriving while frozen are dropped and counted.
//  Ports    : OPB_Clk / OPB_Rst_n         clock, async active-low reset
//             OPB_ABus/BE/DBus/RNW/select OPB master request
//             OPB_seqAddr                 ignored
//             Sl_DBus/xferAck             read data and one-cycle acknowledge
//             Sl_errAck/retry/toutSup     tied low
//             user_data_in/user_valid     fabric word and capture strobe
//             user_fresh                  fresh flag for fabric backpressure
//  Register map (byte offset in the 256-byte window):
//             0x00 R  captured word (read-ack clears fresh)
//             0x04 R  {fresh, 15'b0, ovr_cnt[15:0]}
//             0x08 W  bus bit 0 set -> clear fresh and ovr_cnt
//  Revision : 1.0  initial release
// ============================================================================
// OPB numbers bits MSB-first (bus bit 0 = MSB). The vectors here are declared
// descending, so OPB bit n lives at index WIDTH-1-n: bus bit 0 of the data is
// OPB_DBus[31], BE[0] is OPB_BE[3], and the word index ABus[24:29] is
// OPB_ABus[7:2].
module opb_register_simulink2ppc_latch #(
  parameter logic [31:0] C_BASEADDR   = 32'h01180200,
  parameter logic [31:0] C_HIGHADDR   = 32'h011802FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter bit          C_FREEZE     = 1'b1
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [C_OPB_AWIDTH-1:0]   OPB_ABus,
  input  logic [C_OPB_DWIDTH/8-1:0] OPB_BE,
  input  logic [C_OPB_DWIDTH-1:0]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [C_OPB_DWIDTH-1:0]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid,
  output logic                      user_fresh
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] data_reg;
  logic        fresh;
  logic [15:0] ovr_cnt;

  logic        hit;
  logic [5:0]  word_idx;
  logic        in_ack;
  logic        rd_ack_data;
  logic        clr_write;
  logic        slot_free;
  logic        capture;
  logic        overrun;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign word_idx = OPB_ABus[7:2];
  assign in_ack   = (state == S_ACK);

  // Bus side effects take place on the edge that ends the ACK cycle.
  assign rd_ack_data = in_ack && OPB_RNW && (word_idx == 6'd0);
  assign clr_write   = in_ack && !OPB_RNW && (word_idx == 6'd2) && OPB_BE[3] && OPB_DBus[31];

  // A read-ack of the data word or a clear both empty the slot on this very
  // edge, so a word arriving alongside is taken rather than counted as lost.
  assign slot_free = !C_FREEZE || !fresh || rd_ack_data || clr_write;
  assign capture   = user_valid && slot_free;
  // Losing an unread word counts, whether dropped (frozen) or overwritten.
  assign overrun   = user_valid && fresh && !rd_ack_data && !clr_write;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WAIT holds until select drops so a master holding select gets one ack.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (hit) state_next = S_ACK;
      S_ACK:   state_next = S_WAIT;
      S_WAIT:  if (!OPB_select) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    case (word_idx)
      6'd0:    rdata = data_reg;
      6'd1:    rdata = {fresh, 15'b0, ovr_cnt};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_reg <= 32'h0;
      fresh    <= 1'b0;
      ovr_cnt  <= 16'h0;
    end else begin
      if (capture) begin
        data_reg <= user_data_in;
        fresh    <= 1'b1;
      end else if (rd_ack_data || clr_write) begin
        fresh    <= 1'b0;
      end

      if (clr_write) begin
        ovr_cnt <= 16'h0;
      end else if (overrun && (ovr_cnt != 16'hFFFF)) begin
        ovr_cnt <= ovr_cnt + 16'd1;
      end
    end
  end

  assign Sl_xferAck = in_ack;
  assign Sl_DBus    = (in_ack && OPB_RNW) ? rdata : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_fresh = fresh;

  assign unused_bits = ^{OPB_ABus[1:0], OPB_BE[2:0], OPB_DBus[30:0], OPB_seqAddr};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_opb_register_simulink2ppc_latch
//  Purpose  : directed self-checking bench for opb_register_simulink2ppc_latch
//  Revision : 1.0  initial release
// ============================================================================
module tb_opb_register_simulink2ppc_latch;

  localparam logic [31:0] BASE = 32'h01180200;

  logic        clk;
  logic        rst_n;
  logic [31:0] abus;
  logic [3:0]  be;
  logic [31:0] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;
  logic [31:0] sl_dbus;
  logic        xfer_ack;
  logic        err_ack;
  logic        retry;
  logic        tout_sup;
  logic [31:0] udata;
  logic        uvalid;
  logic        ufresh;

  int checks;
  int errors;

  opb_register_simulink2ppc_latch #(
    .C_BASEADDR   (32'h01180200),
    .C_HIGHADDR   (32'h011802FF),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_FREEZE     (1'b1)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (xfer_ack),
    .Sl_errAck    (err_ack),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout_sup),
    .user_data_in (udata),
    .user_valid   (uvalid),
    .user_fresh   (ufresh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One OPB transfer: select held for 'hold' cycles, then two idle cycles in
  // which any further ack is also counted. Optionally pulses user_valid so it
  // is high on the same edge that ends the ack cycle.
  task automatic xfer(input logic rnw_i, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input logic pulse_on_ack, input logic [31:0] vdata,
                      output logic [31:0] rd, output int acks);
    acks = 0;
    rd   = 32'h0;
    @(posedge clk); #1;
    sel = 1'b1; rnw = rnw_i; abus = addr; dbus = wdata; be = 4'hF;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (xfer_ack) begin
        acks++;
        rd = sl_dbus;
      end
      @(posedge clk); #1;
      if (pulse_on_ack && i == 0) begin
        uvalid = 1'b1; udata = vdata;
      end
      if (i == 1) uvalid = 1'b0;
    end
    sel = 1'b0; rnw = 1'b1; dbus = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (xfer_ack) acks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    @(posedge clk); #1;
    uvalid = 1'b1; udata = d;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (xfer_ack !== 1'b0 || sl_dbus !== 32'h0 || ufresh !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dbus=%h fresh=%b, need 0/0/0", xfer_ack, sl_dbus, ufresh);
    end
    checks++;
    if ({err_ack, retry, tout_sup} !== 3'b000) begin
      errors++;
      $display("FAIL tieoffs: got %b need 000", {err_ack, retry, tout_sup});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_empty_reads();
    logic [31:0] rd;
    int acks;
    xfer(1'b1, BASE + 32'h0, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || acks !== 1) begin
      errors++;
      $display("FAIL empty_data: got %h acks=%0d need 00000000 acks=1", rd, acks);
    end
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || acks !== 1) begin
      errors++;
      $display("FAIL empty_status: got %h acks=%0d need 00000000 acks=1", rd, acks);
    end
  endtask

  task automatic test_capture();
    logic [31:0] rd;
    int acks;
    pulse(32'hDEADBEEF);
    checks++;
    if (ufresh !== 1'b1) begin
      errors++;
      $display("FAIL user_fresh_set: got %b need 1", ufresh);
    end
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h80000000) begin
      errors++;
      $display("FAIL capture_status: got %h need 80000000", rd);
    end
    xfer(1'b1, BASE + 32'h0, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL capture_data: got %h need deadbeef", rd);
    end
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || ufresh !== 1'b0) begin
      errors++;
      $display("FAIL status_after_read: got %h fresh=%b need 00000000 fresh=0", rd, ufresh);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] rd;
    int acks;
    pulse(32'h1);
    pulse(32'h2);
    pulse(32'h3);
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h80000002) begin
      errors++;
      $display("FAIL freeze_status: got %h need 80000002", rd);
    end
    xfer(1'b1, BASE + 32'h0, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL freeze_data: got %h need 00000001", rd);
    end
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h00000002) begin
      errors++;
      $display("FAIL freeze_status_after_read: got %h need 00000002", rd);
    end
  endtask

  task automatic test_clear();
    logic [31:0] rd;
    int acks;
    pulse(32'h55);
    xfer(1'b0, BASE + 32'h8, 32'h80000000, 2, 1'b0, 32'h0, rd, acks);
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL clear_status: got %h need 00000000", rd);
    end
    pulse(32'h66);
    pulse(32'h67);
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h80000001) begin
      errors++;
      $display("FAIL overrun_one: got %h need 80000001", rd);
    end
    // clear and capture on the same edge: capture wins, counter cleared
    xfer(1'b0, BASE + 32'h8, 32'h80000000, 2, 1'b1, 32'h77, rd, acks);
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h80000000) begin
      errors++;
      $display("FAIL clear_with_valid: got %h need 80000000", rd);
    end
    xfer(1'b1, BASE + 32'h8, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || acks !== 1) begin
      errors++;
      $display("FAIL read_ctrl: got %h acks=%0d need 00000000 acks=1", rd, acks);
    end
    xfer(1'b1, BASE + 32'h10, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || acks !== 1) begin
      errors++;
      $display("FAIL read_unmapped: got %h acks=%0d need 00000000 acks=1", rd, acks);
    end
  endtask

  task automatic test_read_with_valid();
    logic [31:0] rd;
    int acks;
    // fresh=1 holding 0x77; read-ack and a new word on the same edge
    xfer(1'b1, BASE + 32'h0, 32'h0, 2, 1'b1, 32'hAB, rd, acks);
    checks++;
    if (rd !== 32'h77) begin
      errors++;
      $display("FAIL read_old_word: got %h need 00000077", rd);
    end
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h80000000) begin
      errors++;
      $display("FAIL read_valid_status: got %h need 80000000", rd);
    end
  endtask

  task automatic test_held_select_and_saturation();
    logic [31:0] rd;
    int acks;
    xfer(1'b1, BASE + 32'h4, 32'h0, 10, 1'b0, 32'h0, rd, acks);
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL held_select_acks: got %0d need 1", acks);
    end
    @(posedge clk); #1;
    uvalid = 1'b1; udata = 32'hCAFE0000;
    repeat (70000) @(posedge clk);
    #1;
    uvalid = 1'b0;
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h8000FFFF) begin
      errors++;
      $display("FAIL ovr_saturate: got %h need 8000ffff", rd);
    end
    xfer(1'b1, BASE + 32'h0, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'hAB) begin
      errors++;
      $display("FAIL frozen_data: got %h need 000000ab", rd);
    end
  endtask

  task automatic test_reset_in_ack();
    logic [31:0] rd;
    int acks;
    pulse(32'h12345678);
    @(posedge clk); #1;
    sel = 1'b1; rnw = 1'b1; abus = BASE;
    @(posedge clk); #1;
    checks++;
    if (xfer_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_before_reset: got %b need 1", xfer_ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (xfer_ack !== 1'b0 || sl_dbus !== 32'h0 || ufresh !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ack: ack=%b dbus=%h fresh=%b need 0/0/0", xfer_ack, sl_dbus, ufresh);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b1, BASE + 32'h4, 32'h0, 2, 1'b0, 32'h0, rd, acks);
    checks++;
    if (rd !== 32'h0 || acks !== 1) begin
      errors++;
      $display("FAIL status_after_reset: got %h acks=%0d need 00000000 acks=1", rd, acks);
    end
    xfer(1'b1, 32'h01180300, 32'h0, 3, 1'b0, 32'h0, rd, acks);
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL above_window: acks=%0d need 0", acks);
    end
    xfer(1'b1, 32'h011801FC, 32'h0, 3, 1'b0, 32'h0, rd, acks);
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL below_window: acks=%0d need 0", acks);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    abus   = 32'h0;
    be     = 4'h0;
    dbus   = 32'h0;
    rnw    = 1'b1;
    sel    = 1'b0;
    seq    = 1'b0;
    udata  = 32'h0;
    uvalid = 1'b0;
    test_reset();
    test_empty_reads();
    test_capture();
    test_freeze();
    test_clear();
    test_read_with_valid();
    test_held_select_and_saturation();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
